// File: rtl/ifu.sv
// ifu: PC register, async-read instruction memory and next-PC select; fetch latency 0, stall holds pc/fetch_cnt
// (program-load writes still proceed). Define IFU_ADDR_CHECK_EN to trap misaligned/out-of-range targets into addr_err.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       npcop,
    input  logic             zero,
    input  logic [31:0]      rs_data,
    input  logic             im_we,
    input  logic [IM_AW-1:0] im_waddr,
    input  logic [31:0]      im_wdata,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [31:0]      fetch_cnt,
    output logic             addr_err
);

    localparam logic [31:0] IM_BYTES = 32'(4 * (2 ** IM_AW));

    logic [31:0] mem [2**IM_AW];
    logic [31:0] pc_off;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        fetch_ok;

    always_ff @(posedge clk) begin
        if (im_we) begin
            mem[im_waddr] <= im_wdata;
        end
    end

    // Addresses below the base or past the array fetch a nop rather than aliasing.
    assign pc_off   = pc - RESET_PC;
    assign fetch_ok = (pc >= RESET_PC) && (pc_off < IM_BYTES);
    assign instr    = fetch_ok ? mem[pc_off[IM_AW+1:2]] : 32'h0;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (npcop)
            2'b01: if (zero) next_pc = pc_plus4 + br_off;
            2'b10: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            2'b11: next_pc = rs_data;
            default: next_pc = pc_plus4;
        endcase
    end

`ifdef IFU_ADDR_CHECK_EN
    logic [31:0] npc_off;
    logic        npc_bad;
    logic        err_q;

    assign npc_off = next_pc - RESET_PC;
    assign npc_bad = (next_pc[1:0] != 2'b00) || (next_pc < RESET_PC) || (npc_off >= IM_BYTES);

    // A bad target latches the error and freezes fetch until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            fetch_cnt <= 32'd0;
            err_q     <= 1'b0;
        end else if (!stall && !err_q) begin
            if (npc_bad) begin
                err_q <= 1'b1;
            end else begin
                pc        <= next_pc;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    assign addr_err = err_q;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            fetch_cnt <= 32'd0;
        end else if (!stall) begin
            pc        <= next_pc;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign addr_err = 1'b0;
`endif

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle MIPS datapath: it holds the PC, reads the instruction word from an internal instruction memory and drives `opcode`/`funct` to the controller. It consumes the controller's `npcop` next-PC selection, together with the ALU `zero` flag and the GPR `rs` value, to compute the next PC. A load port lets the bench or boot logic write program words, and a retired-fetch counter supports debug.

## Interface

- `RESET_PC`, 32'h0000_3000, PC value after reset and base address of the instruction memory.
- `IM_AW`, 10, instruction-memory word-address width (depth = 2^IM_AW words).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC and the counter this cycle.
- `npcop`  in  2  next-PC select: 00 = PC+4, 01 = beq, 10 = j/jal, 11 = jr.
- `zero`  in  1  ALU equality result, used only when npcop=01.
- `rs_data`  in  32  jr target.
- `im_we`  in  1  program-load write enable.
- `im_waddr`  in  IM_AW  program-load word address.
- `im_wdata`  in  32  program-load data.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  PC+4, the jal link value.
- `instr`  out  32  instruction at `pc`.
- `opcode`  out  6  instr[31:26].
- `funct`  out  6  instr[5:0].
- `fetch_cnt`  out  32  count of PC advances since reset.
- `addr_err`  out  1  sticky fetch-address error (see Configuration).

## Operation

- Instruction memory: array of 2^IM_AW × 32-bit words, asynchronous read.
  - Word index = (pc − RESET_PC)[IM_AW+1:2].
  - If pc < RESET_PC or index ≥ 2^IM_AW, `instr` = 32'h0 (nop).
- `opcode`, `funct` and `pc_plus4` are combinational from `instr`/`pc`.
- Next-PC computation (all arithmetic 32-bit, wraps mod 2^32):
  - 00: pc+4.
  - 01: if `zero`, pc+4 + (sign-extended instr[15:0] << 2); otherwise pc+4.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: rs_data.
- Register update on each rising edge with `stall`=0: pc ← next PC, fetch_cnt ← fetch_cnt+1 (wraps at 2^32).
- With `stall`=1: pc and fetch_cnt hold; next-PC inputs are ignored.
- Program load: on a rising edge with `im_we`=1, mem[im_waddr] ← im_wdata. `stall` has no effect on writes.
- Reset: pc=RESET_PC, fetch_cnt=0, addr_err=0.
  - Memory contents are not cleared by reset.
  - Outputs immediately reflect mem[0].

## Timing

- Fetch latency 0: `instr`, `opcode` and `funct` are valid in the same cycle as `pc`, after combinational delay.
- A PC change is visible one edge after the `npcop` selection is presented.
- Write to the word currently addressed by pc: `instr` shows the old value until the edge and the new value after it. There is no bypass.
- Simultaneous write and PC advance: the write uses `im_waddr`; the fetch after the edge reads the updated array.
- Reset asserted mid-cycle: pc and fetch_cnt clear immediately, without waiting for a clock edge. Deassertion is expected to be synchronous to `clk` externally.

## Configuration

- `IFU_ADDR_CHECK_EN` defined:
  - A candidate next PC is an error if its low 2 bits ≠ 0 or it falls outside [RESET_PC, RESET_PC + 4·2^IM_AW).
  - On an error at an advancing edge, `addr_err` ← 1 and pc is not updated (it holds its current value). fetch_cnt also holds.
  - Once `addr_err`=1, pc and fetch_cnt freeze until reset.
- `IFU_ADDR_CHECK_EN` undefined:
  - `addr_err` is tied to 0.
  - Any next PC is accepted; low 2 bits are ignored for indexing.
  - Out-of-range PCs fetch 0.

## Test plan

- Reset → pc=0x3000, fetch_cnt=0, addr_err=0. Load `slt` (0x0109502A) at word 0 and release reset → opcode=0, funct=0x2A.
- 5 edges with npcop=00 → pc=0x3014, fetch_cnt=5. Assert stall for 2 edges → pc and fetch_cnt unchanged.
- beq, imm16=0xFFFE at pc=0x3010, npcop=01: with zero=1 → next pc=0x300C; with zero=0 → 0x3014.
- j with instr[25:0]=0x0000C08 at pc=0x3000, npcop=10 → pc=0x3020. jr with rs_data=0x3040, npcop=11 → pc=0x3040. pc_plus4 = pc+4 throughout.
- Write 0x3C010001 to the currently fetched word mid-cycle → `instr` unchanged before the edge, opcode=0x0F after it. Pulse reset mid-cycle → pc=0x3000 without waiting for a clock edge.
- With `IFU_ADDR_CHECK_EN`: jr to 0x3042 → addr_err=1 and pc holds. Further edges leave pc and fetch_cnt unchanged until reset. Without the macro: addr_err stays 0 and instr=0 for out-of-range pc.
